// File: rtl/uncrop_pkg.sv
// Shared types and default geometry for the uncrop filter, which pastes a cropped image into a padded frame.
package uncrop_pkg;

    localparam int DEF_PIXEL_BIT_WIDTH  = 16;
    localparam int DEF_CROP_ROWS        = 48;
    localparam int DEF_CROP_COLS        = 48;
    localparam int DEF_FRAME_ROWS       = 100;
    localparam int DEF_FRAME_COLS       = 160;
    localparam int DEF_IMG_ROW_BITWIDTH = 10;
    localparam int DEF_IMG_COL_BITWIDTH = 10;
    localparam int DEF_PAD_VALUE        = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/uncrop_filter_if.sv
// Valid/ready stream bundle used between the frame generator and the output register.
interface uncrop_filter_if #(
    parameter int W = 16
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uncrop_out_reg.sv
// Single-stage valid/ready output register: full throughput, data held stable while stalled.
module uncrop_out_reg #(
    parameter int W = 16
) (
    input logic             clk,
    input logic             reset,
    uncrop_filter_if.slave  src,
    uncrop_filter_if.master dst
);

    logic         valid_r;
    logic [W-1:0] data_r;

    assign src.tready = !valid_r || dst.tready;
    assign dst.tvalid = valid_r;
    assign dst.tdata  = data_r;

    // Load when empty or draining; otherwise drop valid once the held word leaves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (src.tvalid && src.tready) begin
            valid_r <= 1'b1;
            data_r  <= src.tdata;
        end else if (dst.tready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/uncrop_filter.sv
// Uncrop filter: pastes a CROP_ROWS x CROP_COLS stream into a FRAME_ROWS x FRAME_COLS frame at (Y1,X1).
// Optional macro UNCROP_TLAST_EN adds pixel_out_TLAST marking the final frame word.
module uncrop_filter
    import uncrop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = DEF_PIXEL_BIT_WIDTH,
    parameter int CROP_ROWS        = DEF_CROP_ROWS,
    parameter int CROP_COLS        = DEF_CROP_COLS,
    parameter int FRAME_ROWS       = DEF_FRAME_ROWS,
    parameter int FRAME_COLS       = DEF_FRAME_COLS,
    parameter int IMG_ROW_BITWIDTH = DEF_IMG_ROW_BITWIDTH,
    parameter int IMG_COL_BITWIDTH = DEF_IMG_COL_BITWIDTH,
    parameter int PAD_VALUE        = DEF_PAD_VALUE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
    input  logic                        crop_Y1_TVALID,
    output logic                        crop_Y1_TREADY,
    input  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
    input  logic                        crop_X1_TVALID,
    output logic                        crop_X1_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0]  pixel_in_TDATA,
    input  logic                        pixel_in_TVALID,
    output logic                        pixel_in_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA,
    output logic                        pixel_out_TVALID,
    input  logic                        pixel_out_TREADY
`ifdef UNCROP_TLAST_EN
    ,
    output logic                        pixel_out_TLAST
`endif
);

    localparam int RW = IMG_ROW_BITWIDTH;
    localparam int CW = IMG_COL_BITWIDTH;
    localparam logic [RW-1:0] Y1_MAX   = RW'(FRAME_ROWS - CROP_ROWS);
    localparam logic [CW-1:0] X1_MAX   = CW'(FRAME_COLS - CROP_COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(FRAME_COLS - 1);
    localparam logic [PIXEL_BIT_WIDTH-1:0] PAD = PIXEL_BIT_WIDTH'(PAD_VALUE);
`ifdef UNCROP_TLAST_EN
    localparam int OW = PIXEL_BIT_WIDTH + 1;
`else
    localparam int OW = PIXEL_BIT_WIDTH;
`endif

    state_t                     state_r;
    logic                       y1_held_r;
    logic                       x1_held_r;
    logic                       all_loaded_r;
    logic [RW-1:0]              y1_r;
    logic [CW-1:0]              x1_r;
    logic [RW-1:0]              row_r;
    logic [CW-1:0]              col_r;
    logic [RW:0]                row_end_s;
    logic [CW:0]                col_end_s;
    logic                       inside_s;
    logic                       last_pos_s;
    logic                       active_s;
    logic                       load_s;
    logic                       done_s;
    logic [PIXEL_BIT_WIDTH-1:0] gen_pix_s;

    uncrop_filter_if #(.W(OW)) gen_if ();
    uncrop_filter_if #(.W(OW)) out_if ();

    // Window end bounds carry an extra bit so Y1+CROP_ROWS / X1+CROP_COLS cannot wrap.
    assign row_end_s  = {1'b0, y1_r} + (RW+1)'(CROP_ROWS);
    assign col_end_s  = {1'b0, x1_r} + (CW+1)'(CROP_COLS);
    assign inside_s   = ({1'b0, row_r} >= {1'b0, y1_r}) && ({1'b0, row_r} < row_end_s) &&
                        ({1'b0, col_r} >= {1'b0, x1_r}) && ({1'b0, col_r} < col_end_s);
    assign last_pos_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
    assign active_s   = (state_r == RUN) && !all_loaded_r;

    assign crop_Y1_TREADY = reset && (state_r == IDLE) && !y1_held_r;
    assign crop_X1_TREADY = reset && (state_r == IDLE) && !x1_held_r;

    // Inside the window forward the input stream; outside it, offer padding without touching input.
    always_comb begin
        gen_if.tvalid   = 1'b0;
        pixel_in_TREADY = 1'b0;
        gen_pix_s       = PAD;
        if (active_s && inside_s) begin
            gen_if.tvalid   = pixel_in_TVALID;
            pixel_in_TREADY = gen_if.tready;
            gen_pix_s       = pixel_in_TDATA;
        end else if (active_s) begin
            gen_if.tvalid   = 1'b1;
            pixel_in_TREADY = 1'b0;
            gen_pix_s       = PAD;
        end else begin
            gen_if.tvalid   = 1'b0;
            pixel_in_TREADY = 1'b0;
            gen_pix_s       = PAD;
        end
    end

`ifdef UNCROP_TLAST_EN
    assign gen_if.tdata     = {last_pos_s, gen_pix_s};
    assign pixel_out_TDATA  = out_if.tdata[PIXEL_BIT_WIDTH-1:0];
    assign pixel_out_TLAST  = out_if.tdata[OW-1];
`else
    assign gen_if.tdata     = gen_pix_s;
    assign pixel_out_TDATA  = out_if.tdata;
`endif
    assign pixel_out_TVALID = out_if.tvalid;
    assign out_if.tready    = pixel_out_TREADY;

    assign load_s = gen_if.tvalid && gen_if.tready;
    assign done_s = all_loaded_r && out_if.tvalid && out_if.tready;

    uncrop_out_reg #(.W(OW)) u_out_reg (
        .clk   (clk),
        .reset (reset),
        .src   (gen_if.slave),
        .dst   (out_if.master)
    );

    // Control FSM: capture clamped coordinates in IDLE, walk the frame in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            y1_held_r    <= 1'b0;
            x1_held_r    <= 1'b0;
            all_loaded_r <= 1'b0;
            y1_r         <= '0;
            x1_r         <= '0;
            row_r        <= '0;
            col_r        <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (crop_Y1_TVALID && crop_Y1_TREADY) begin
                        y1_r      <= (crop_Y1_TDATA > Y1_MAX) ? Y1_MAX : crop_Y1_TDATA;
                        y1_held_r <= 1'b1;
                    end
                    if (crop_X1_TVALID && crop_X1_TREADY) begin
                        x1_r      <= (crop_X1_TDATA > X1_MAX) ? X1_MAX : crop_X1_TDATA;
                        x1_held_r <= 1'b1;
                    end
                    if (y1_held_r && x1_held_r) begin
                        state_r      <= RUN;
                        row_r        <= '0;
                        col_r        <= '0;
                        all_loaded_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (load_s) begin
                        if (last_pos_s) begin
                            all_loaded_r <= 1'b1;
                            row_r        <= '0;
                            col_r        <= '0;
                        end else if (col_r == COL_LAST) begin
                            col_r <= '0;
                            row_r <= row_r + 1'b1;
                        end else begin
                            col_r <= col_r + 1'b1;
                        end
                    end
                    // Frame ends only once the final word has actually left the output register.
                    if (done_s) begin
                        state_r      <= IDLE;
                        y1_held_r    <= 1'b0;
                        x1_held_r    <= 1'b0;
                        all_loaded_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uncrop_filter.sv
// Self-checking bench for uncrop_filter: a frame-level model built from the paste-window rules, driven by (random) streams.
`timescale 1ns/1ps
module tb_uncrop_filter;

    localparam int PW      = 16;
    localparam int RW      = 10;
    localparam int CW      = 10;
    localparam int CR      = 48;
    localparam int CC      = 48;
    localparam int FR      = 100;
    localparam int FC      = 160;
    localparam int NW      = FR * FC;
    localparam int NIN     = CR * CC;
    localparam int MAX_CYC = 60000;
    localparam logic [PW-1:0] PADV = 16'd0;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uncrop_filter_if #(.W(RW)) y_if ();
    uncrop_filter_if #(.W(CW)) x_if ();
    uncrop_filter_if #(.W(PW)) in_if ();
    uncrop_filter_if #(.W(PW)) out_if ();
`ifdef UNCROP_TLAST_EN
    logic tlast;
`endif

    uncrop_filter dut (
        .clk              (clk),
        .reset            (reset),
        .crop_Y1_TDATA    (y_if.tdata),
        .crop_Y1_TVALID   (y_if.tvalid),
        .crop_Y1_TREADY   (y_if.tready),
        .crop_X1_TDATA    (x_if.tdata),
        .crop_X1_TVALID   (x_if.tvalid),
        .crop_X1_TREADY   (x_if.tready),
        .pixel_in_TDATA   (in_if.tdata),
        .pixel_in_TVALID  (in_if.tvalid),
        .pixel_in_TREADY  (in_if.tready),
        .pixel_out_TDATA  (out_if.tdata),
        .pixel_out_TVALID (out_if.tvalid),
        .pixel_out_TREADY (out_if.tready)
`ifdef UNCROP_TLAST_EN
        ,
        .pixel_out_TLAST  (tlast)
`endif
    );

    int checks   = 0;
    int failures = 0;
    logic [PW-1:0] in_vals   [NIN];
    logic [PW-1:0] got       [NW];
    logic [PW-1:0] ref_frame [NW];
    logic [PW-1:0] exp_q     [$];
    logic [PW-1:0] exp_word;
    logic [PW-1:0] stall_data;
    int  rx_cnt     = 0;
    int  in_cnt     = 0;
    bit  rand_mode  = 1'b0;
    bit  stop_drv   = 1'b0;
    bit  stall_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (word %0d)", name, act, req, rx_cnt);
        end
    endtask

    function automatic void fill_inputs(input bit rnd);
        for (int i = 0; i < NIN; i++) in_vals[i] = rnd ? PW'($urandom) : PW'(i);
    endfunction

    // Golden frame: clamp the corner, then every position is either the next crop pixel or padding.
    function automatic void build_expected(input int y, input int x);
        int yc = (y > FR - CR) ? FR - CR : y;
        int xc = (x > FC - CC) ? FC - CC : x;
        exp_q.delete();
        for (int r = 0; r < FR; r++)
            for (int c = 0; c < FC; c++)
                if (r >= yc && r < yc + CR && c >= xc && c < xc + CC)
                    exp_q.push_back(in_vals[(r - yc) * CC + (c - xc)]);
                else
                    exp_q.push_back(PADV);
    endfunction

    // Output monitor: every transferred word is checked against the golden frame, stalls must hold data.
    always @(negedge clk) begin
        if (!reset) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid", 32'(out_if.tvalid), 32'd1);
                check("stall_data", 32'(out_if.tdata), 32'(stall_data));
            end
            stall_pend = out_if.tvalid && !out_if.tready;
            stall_data = out_if.tdata;
            if (out_if.tvalid && out_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("pixel", 32'(out_if.tdata), 32'(exp_word));
`ifdef UNCROP_TLAST_EN
                    check("tlast", 32'(tlast), 32'(rx_cnt == NW - 1));
`endif
                    if (rx_cnt == 100) begin
                        check("run_y_ready_low", 32'(y_if.tready), 32'd0);
                        check("run_x_ready_low", 32'(x_if.tready), 32'd0);
                    end
                    got[rx_cnt] = out_if.tdata;
                    rx_cnt++;
                end
            end
        end
    end

    task automatic coord_drv(input bit is_y, input int v);
        bit f = 1'b0;
        if (rand_mode) repeat ($urandom_range(6, 0)) begin @(posedge clk); #1; end
        if (is_y) begin y_if.tdata = RW'(v); y_if.tvalid = 1'b1; end
        else      begin x_if.tdata = CW'(v); x_if.tvalid = 1'b1; end
        while (!f && !stop_drv) begin
            @(negedge clk);
            f = is_y ? (y_if.tvalid && y_if.tready) : (x_if.tvalid && x_if.tready);
            @(posedge clk); #1;
        end
        if (is_y) y_if.tvalid = 1'b0;
        else      x_if.tvalid = 1'b0;
    endtask

    task automatic pix_drv();
        int i = 0;
        bit f;
        in_if.tvalid = 1'b0;
        while (i < NIN && !stop_drv) begin
            if (!in_if.tvalid) begin
                in_if.tvalid = !rand_mode || ($urandom_range(1, 0) == 1);
                in_if.tdata  = in_vals[i];
            end
            @(negedge clk);
            f = in_if.tvalid && in_if.tready;
            @(posedge clk); #1;
            if (f) begin
                i++;
                in_cnt++;
                in_if.tvalid = 1'b0;
            end
        end
        in_if.tvalid = 1'b0;
    endtask

    task automatic sink_drv();
        while (!stop_drv) begin
            out_if.tready = !rand_mode || ($urandom_range(1, 0) == 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_frame(input int y, input int x, input int stop_at, input bit abort);
        int cyc = 0;
        build_expected(y, x);
        rx_cnt   = 0;
        in_cnt   = 0;
        stop_drv = 1'b0;
        fork
            coord_drv(1'b1, y);
            coord_drv(1'b0, x);
            pix_drv();
            sink_drv();
        join_none
        while (rx_cnt < stop_at && cyc < MAX_CYC) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (abort) reset = 1'b0;
        check("frame_words", rx_cnt, stop_at);
        stop_drv = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        out_if.tready = 1'b1;
        stop_drv = 1'b0;
        if (!abort) begin
            check("no_residual_expect", exp_q.size(), 0);
            check("inputs_consumed", in_cnt, NIN);
            check("idle_y_ready", 32'(y_if.tready), 32'd1);
            check("idle_x_ready", 32'(x_if.tready), 32'd1);
            check("idle_in_ready", 32'(in_if.tready), 32'd0);
            check("idle_out_valid", 32'(out_if.tvalid), 32'd0);
        end
    endtask

    initial begin
        int diff;
        y_if.tdata = '0;  y_if.tvalid = 1'b0;
        x_if.tdata = '0;  x_if.tvalid = 1'b0;
        in_if.tdata = '0; in_if.tvalid = 1'b0;
        out_if.tready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_if.tvalid), 32'd0);
        check("rst_out_data", 32'(out_if.tdata), 32'd0);
        check("rst_y_ready", 32'(y_if.tready), 32'd0);
        check("rst_x_ready", 32'(x_if.tready), 32'd0);
        check("rst_in_ready", 32'(in_if.tready), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("post_rst_y_ready", 32'(y_if.tready), 32'd1);
        check("post_rst_out_valid", 32'(out_if.tvalid), 32'd0);
        @(posedge clk); #1;

        rand_mode = 1'b0;
        fill_inputs(1'b0);
        run_frame(52, 112, NW, 1'b0);
        check("corner_last", 32'(got[NW - 1]), 32'd2303);
        check("corner_pad_left", 32'(got[52 * 160 + 111]), 32'(PADV));
        check("corner_first", 32'(got[52 * 160 + 112]), 32'd0);
        check("corner_second", 32'(got[52 * 160 + 113]), 32'd1);
        ref_frame = got;

        run_frame(60, 200, NW, 1'b0);
        diff = 0;
        for (int i = 0; i < NW; i++) if (got[i] !== ref_frame[i]) diff++;
        check("clamped_equals_corner", diff, 0);

        rand_mode = 1'b1;
        fill_inputs(1'b1);
        run_frame(37, 59, NW, 1'b0);

        rand_mode = 1'b0;
        fill_inputs(1'b0);
        run_frame(52, 112, 5000, 1'b1);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_if.tvalid), 32'd0);
        check("midrst_out_data", 32'(out_if.tdata), 32'd0);
        check("midrst_in_ready", 32'(in_if.tready), 32'd0);
        check("midrst_y_ready", 32'(y_if.tready), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("after_rst_out_valid", 32'(out_if.tvalid), 32'd0);
        check("after_rst_y_ready", 32'(y_if.tready), 32'd1);
        @(posedge clk); #1;

        run_frame(0, 0, NW, 1'b0);
        check("origin_w0", 32'(got[0]), 32'd0);
        check("origin_w47", 32'(got[47]), 32'd47);
        check("origin_w48", 32'(got[48]), 32'(PADV));
        check("origin_w160", 32'(got[160]), 32'd48);
        check("origin_total", rx_cnt, 16000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uncrop_filter.md
UNCROP_FILTER -- requirements
Module: uncrop_filter

Interface
REQ-001 SHALL have parameter PIXEL_BIT_WIDTH, default 16: pixel word width.
REQ-002 SHALL have parameter CROP_ROWS, default 48: rows of the incoming cropped image.
REQ-003 SHALL have parameter CROP_COLS, default 48: columns of the incoming cropped image.
REQ-004 SHALL have parameter FRAME_ROWS, default 100: rows of the emitted frame.
REQ-005 SHALL have parameter FRAME_COLS, default 160: columns of the emitted frame.
REQ-006 SHALL have parameter IMG_ROW_BITWIDTH, default 10: row-coordinate width.
REQ-007 SHALL have parameter IMG_COL_BITWIDTH, default 10: column-coordinate width.
REQ-008 SHALL have parameter PAD_VALUE, default 0: pixel value emitted outside the crop window.
REQ-009 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-010 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-011 SHALL have ports crop_Y1_TDATA/TVALID/TREADY (in IMG_ROW_BITWIDTH / in 1 / out 1): top row of the paste window.
REQ-012 SHALL have ports crop_X1_TDATA/TVALID/TREADY (in IMG_COL_BITWIDTH / in 1 / out 1): left column of the paste window.
REQ-013 SHALL have ports pixel_in_TDATA/TVALID/TREADY (in PIXEL_BIT_WIDTH / in 1 / out 1): cropped pixels, raster order.
REQ-014 SHALL have ports pixel_out_TDATA/TVALID/TREADY (out PIXEL_BIT_WIDTH / out 1 / in 1): full frame, raster order.

Function
REQ-015 A transfer SHALL occur on a rising edge where TVALID and TREADY are both high; a producer SHALL NOT drop TVALID or change TDATA before the transfer.
REQ-016 The FSM SHALL have states IDLE and RUN; the block SHALL leave reset in IDLE.
REQ-017 In IDLE, crop_Y1_TREADY and crop_X1_TREADY SHALL each be high while the matching coordinate is not yet captured, and each coordinate SHALL be captured independently.
REQ-018 IDLE SHALL go to RUN on the cycle after both coordinates are held; both coordinate TREADYs SHALL be low in RUN.
REQ-019 Y1 > FRAME_ROWS-CROP_ROWS SHALL be clamped to FRAME_ROWS-CROP_ROWS; X1 > FRAME_COLS-CROP_COLS SHALL be clamped to FRAME_COLS-CROP_COLS.
REQ-020 In RUN, row/col counters SHALL walk the frame in raster order; col wraps at FRAME_COLS-1 and row then increments.
REQ-021 Frame position (r,c) is inside the window iff Y1<=r<Y1+CROP_ROWS and X1<=c<X1+CROP_COLS.
REQ-022 Inside the window, the next pixel_in word SHALL be emitted; outside it, PAD_VALUE SHALL be emitted without consuming input.
REQ-023 pixel_in_TREADY SHALL be high only in RUN, at an inside position, with the output register empty or draining this cycle.
REQ-024 The output register SHALL be a single stage: data SHALL appear on pixel_out one cycle after it is accepted or generated; with TREADY held high, throughput SHALL be 1 pixel/cycle.
REQ-025 Output SHALL stall on pixel_out_TREADY low with TDATA stable; counters SHALL advance only when a word loads into the register.
REQ-026 After the last frame word is transferred, the FSM SHALL return to IDLE and clear both coordinate-held flags; exactly CROP_ROWS*CROP_COLS inputs SHALL be consumed per frame.
REQ-027 Counter widths SHALL be IMG_ROW_BITWIDTH/IMG_COL_BITWIDTH; window bounds SHALL be computed one bit wider to avoid overflow.

Reset
REQ-028 On reset low, asynchronously: state=IDLE, counters=0, coordinate flags cleared, pixel_out_TVALID=0, pixel_out_TDATA=0, all TREADY outputs=0 while asserted.
REQ-029 Reset mid-frame SHALL discard the partial frame and captured coordinates; no stale word SHALL be presented after release.

Configuration
REQ-030 Macro UNCROP_TLAST_EN defined: output port pixel_out_TLAST (1 bit, reset 0), high with the final frame word (r=FRAME_ROWS-1, c=FRAME_COLS-1) and held with it under stall. Undefined: the port and its logic SHALL be absent, with no other behaviour change.

Structure
REQ-031 Package uncrop_pkg SHALL hold the FSM state enum typedef and the default geometry/width constants.
REQ-032 Sub-module uncrop_out_reg SHALL implement the single-stage valid/ready output register; the counters and FSM SHALL stay in uncrop_filter.

Verification
REQ-033 Y1=0, X1=0, input words 0..2303, TREADY=1: out[0]=0, out[47]=47, out[48]=PAD, out[160]=48; total 16000 words.
REQ-034 Y1=52, X1=112: out[15999]=2303, out[52*160+111]=PAD, out[52*160+112]=0.
REQ-035 Y1=60, X1=200 applied: output identical to REQ-034 (clamping).
REQ-036 Random 50% TVALID/TREADY on all streams, Y1=37, X1=59: output matches the golden frame, no word dropped or duplicated, TDATA stable under stall.
REQ-037 Reset low at output word 5000, then new coordinates Y1=0, X1=0: full correct frame from word 0, no residual TVALID.
REQ-038 UNCROP_TLAST_EN defined: TLAST high only on word 15999; undefined: the bench compiles without the port.
